// File: rtl/pes_bc_pkg.sv
// Shared types for the bidirectional-counter direction controller:
// FSM state encoding, direction constants and a state-to-direction helper.
package pes_bc_pkg;

    typedef enum logic [1:0] {
        MAN_UP,
        MAN_DOWN,
        AUTO_UP,
        AUTO_DOWN
    } dir_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic logic stateDir(input dir_state_t s);
        return ((s == MAN_UP) || (s == AUTO_UP)) ? DIR_UP : DIR_DOWN;
    endfunction

endpackage

// File: rtl/pes_bc_debounce.sv
// One pushbutton front end: 2-flop synchroniser, saturating-mismatch debouncer
// and a single-cycle press pulse on each debounced rising edge.
module pes_bc_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic Clk,
    input  logic reset,
    input  logic btnRaw_i,
    output logic press_o
);

    localparam int CW = $clog2(DEB_CYCLES);

    logic          sync1_q, sync2_q;
    logic          db_q, db_d;
    logic          dbDly_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // The debounced level only follows sync2 after DEB_CYCLES consecutive mismatches.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            dbDly_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btnRaw_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            dbDly_q <= db_q;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = db_q & ~dbDly_q;

endmodule

// File: rtl/pes_bc_dir_ctrl.sv
// Direction controller feeding the 4-bit counter's UpOrDown input: manual
// direction from debounced buttons, or ping-pong reversal at the range ends.
module pes_bc_dir_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 4,
    parameter int CNT_MAX    = 15
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             auto_mode,
    input  logic [CNT_W-1:0] Count,
    output logic             UpOrDown,
    output logic             dir_changed
);

    import pes_bc_pkg::*;

    dir_state_t state_q, state_d;
    logic       upOrDown_q, dirChanged_q;
    logic       dirNext;
    logic       pressUp, pressDown;

    pes_bc_debounce #(.DEB_CYCLES(DEB_CYCLES)) uDebUp (
        .Clk      (Clk),
        .reset    (reset),
        .btnRaw_i (btn_up),
        .press_o  (pressUp)
    );

    pes_bc_debounce #(.DEB_CYCLES(DEB_CYCLES)) uDebDown (
        .Clk      (Clk),
        .reset    (reset),
        .btnRaw_i (btn_down),
        .press_o  (pressDown)
    );

    // Turning one value early lets the counter land on the end value and reverse from it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MAN_UP, MAN_DOWN: begin
                if (auto_mode) begin
                    state_d = (state_q == MAN_UP) ? AUTO_UP : AUTO_DOWN;
                end else if (pressUp && !pressDown) begin
                    state_d = MAN_UP;
                end else if (pressDown && !pressUp) begin
                    state_d = MAN_DOWN;
                end
            end
            AUTO_UP: begin
                if (!auto_mode) begin
                    state_d = MAN_UP;
                end else if (Count == CNT_W'(CNT_MAX - 1)) begin
                    state_d = AUTO_DOWN;
                end
            end
            AUTO_DOWN: begin
                if (!auto_mode) begin
                    state_d = MAN_DOWN;
                end else if (Count == CNT_W'(1)) begin
                    state_d = AUTO_UP;
                end
            end
            default: state_d = MAN_UP;
        endcase
    end

    assign dirNext = stateDir(state_d);

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q      <= MAN_UP;
            upOrDown_q   <= DIR_UP;
            dirChanged_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            upOrDown_q   <= dirNext;
            dirChanged_q <= (dirNext != upOrDown_q);
        end
    end

    assign UpOrDown    = upOrDown_q;
    assign dir_changed = dirChanged_q;

endmodule

// File: doc/pes_bc_dir_ctrl.md
Name: pes_bc_dir_ctrl

Overview:
- Direction controller directly upstream of the 4-bit bidirectional counter; drives the counter's UpOrDown input.
- Manual mode: debounced "up" and "down" pushbuttons set the count direction.
- Auto mode: monitors the counter's Count output and reverses direction at the ends of the range, producing ping-pong counting (0..15..0).
- Also emits a one-cycle pulse whenever the direction changes.

Parameters:
- DEB_CYCLES, 4: consecutive cycles a synchronised button level must differ from its debounced level before the debounced level flips; legal range >= 2.
- CNT_W, 4: width of the Count feedback input.
- CNT_MAX, 15: top of the counter range; must equal 2^CNT_W - 1.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_up  input  1  raw, asynchronous "count up" pushbutton.
- btn_down  input  1  raw, asynchronous "count down" pushbutton.
- auto_mode  input  1  synchronous level; 1 selects ping-pong auto mode.
- Count  input  CNT_W  current counter value, fed back from the counter.
- UpOrDown  output  1  registered direction; 1 = up, 0 = down.
- dir_changed  output  1  registered one-cycle pulse, high in the cycle UpOrDown takes a new value.

Behaviour:
- Reset: one clock, one synchronous active-high reset. While reset is high at an edge, the following are cleared on that edge:
  - sync flops, debounced levels and debounce counters -> 0;
  - FSM state -> MAN_UP;
  - UpOrDown -> 1, dir_changed -> 0.
  - Reset mid-operation behaves identically; no press event is generated by reset release itself.
- Synchroniser: 2-flop per button. A raw change before edge k is visible at sync2 after edge k+1.
- Debounce, per button; counter width is clog2(DEB_CYCLES):
  - if sync2 == db: counter <= 0;
  - else if counter == DEB_CYCLES-1: db <= sync2, counter <= 0;
  - else counter <= counter + 1.
  - A mismatch lasting fewer than DEB_CYCLES cycles never changes db.
- Press event: combinational (db & ~db_q), where db_q is db delayed one cycle. Exactly one cycle per debounced rising edge. Release generates no event.
- Latency: btn_up rising before edge 1 -> db high after edge 2+DEB_CYCLES -> UpOrDown updates at edge 3+DEB_CYCLES (edge 7 at default).
- FSM states: MAN_UP, MAN_DOWN, AUTO_UP, AUTO_DOWN. UpOrDown = 1 in MAN_UP and AUTO_UP, 0 otherwise; it is a registered copy of the state's direction.
- MAN_x transitions:
  - auto_mode = 1 -> AUTO_x with the same direction; auto_mode takes priority over presses.
  - else press_up only -> MAN_UP.
  - else press_down only -> MAN_DOWN.
  - Both presses in the same cycle -> hold state.
- AUTO_UP transitions:
  - auto_mode = 0 -> MAN_UP.
  - else Count == CNT_MAX-1 -> AUTO_DOWN.
  - else hold.
- AUTO_DOWN transitions:
  - auto_mode = 0 -> MAN_DOWN.
  - else Count == 1 -> AUTO_UP.
  - else hold.
- Button presses are ignored in the AUTO states.
- Turn timing: the turn registers on the same edge on which the counter steps to CNT_MAX (or 0). The counter therefore holds direction for that value only, giving the sequence ..14,15,14.. and ..1,0,1..
- Auto entry at an end value: entering AUTO_UP with Count == CNT_MAX (or AUTO_DOWN with Count == 0) allows one wrap-around step, then turns at the next qualifying value. This is accepted behaviour.
- dir_changed: 1 in the cycle after any edge where UpOrDown changed value; otherwise 0. A press that requests the current direction produces no pulse.

Decomposition:
- Shared package pes_bc_pkg holds:
  - the FSM state enum (dir_state_t: MAN_UP, MAN_DOWN, AUTO_UP, AUTO_DOWN);
  - constants DIR_UP = 1'b1 and DIR_DOWN = 1'b0.
- One sub-module, pes_bc_debounce (2-flop sync + debounce counter + press pulse, parameter DEB_CYCLES), instantiated twice.

Test Plan:
- Reset: assert reset 2 cycles with buttons active -> UpOrDown = 1, dir_changed = 0, no press pulse after release.
- Manual down, DEB_CYCLES = 4: btn_down held high from before edge 1 -> UpOrDown 1->0 at edge 7, dir_changed high for exactly that cycle; release -> no further change.
- Glitch rejection: btn_up pulse 3 cycles wide while in MAN_DOWN -> UpOrDown stays 0. A pulse of 5 cycles -> UpOrDown = 1 at edge 3+DEB_CYCLES after the rise.
- Simultaneous presses: btn_up and btn_down rise in the same cycle from MAN_DOWN -> state holds, UpOrDown = 0, no dir_changed.
- Auto ping-pong with behavioural counter model from Count = 0, auto_mode = 1 -> Count sequence 0..15,14..0,1..; UpOrDown falls on the edge Count becomes 15 and rises on the edge Count becomes 0. Drop auto_mode mid-sweep -> state becomes MAN_x with the same direction, and counting continues with wrap.
- Reset mid-auto at Count = 9 going down -> next cycle UpOrDown = 1, state MAN_UP, dir_changed = 0.
